// File: rtl/mem_access_pkg.sv
// Shared definitions for the byte-serial memory access unit: FSM state
// encodings, access-size encodings and the size-to-last-byte helper.
package mem_access_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // req_size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Index of the final byte lane for a legal access size.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            SZ_BYTE: last_index = 2'd0;
            SZ_HALF: last_index = 2'd1;
            default: last_index = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane_seq.sv
// Byte-lane sequencer: holds the base address of the current access, walks
// a byte index from 0 upward, and produces base+index wrapped to ADDR_W bits
// together with a flag marking the final byte of the access.
module mau_lane_seq #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [1:0]        last_idx_i,
    output logic [1:0]        idx_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] base_q;
    logic [1:0]        idx_q;
    logic [1:0]        last_idx_q;

    // Load base/length on start, step the byte index on advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q     <= '0;
            idx_q      <= 2'd0;
            last_idx_q <= 2'd0;
        end else if (start_i) begin
            base_q     <= base_i;
            idx_q      <= 2'd0;
            last_idx_q <= last_idx_i;
        end else if (advance_i) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    // Addition truncates to ADDR_W bits, which gives the all-ones -> 0 wrap.
    assign addr_o = base_q + ADDR_W'(idx_q);
    assign idx_o  = idx_q;
    assign last_o = (idx_q == last_idx_q);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit that serialises byte, halfword and word accesses onto an
// 8-bit memory port, little-endian, one byte per cycle.
// Optional build macro: MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned
// halfword/word requests instead of performing them byte-wise.
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so req_valid is
// ignored while an access is in flight. rsp_valid is a one-cycle pulse and
// rsp_err / rsp_rdata are meaningful only while it is high (rsp_rdata
// additionally holds its value until the next load completes).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_write_data,
    output logic              mem_write_enable,
    input  logic [7:0]        mem_read_data,
    output logic [1:0]        dbg_state
);

    logic [1:0]  state_q, state_d;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] ld_buf_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        misaligned;
    logic        reject;
    logic        in_xfer;
    logic [1:0]  idx;
    logic        last;
    logic [31:0] ld_next;
    logic [7:0]  wr_byte;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign accept  = req_valid && (state_q == ST_IDLE);
    assign reject  = (req_size == SZ_RSVD) || misaligned;
    assign in_xfer = (state_q == ST_XFER);

    generate
        if (ADDR_W < 32) begin : g_addr_hi
            // Address bits above ADDR_W are deliberately discarded.
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[31:ADDR_W];
        end
    endgenerate

    mau_lane_seq #(.ADDR_W(ADDR_W)) u_lane_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (accept && !reject),
        .advance_i  (in_xfer && !last),
        .base_i     (req_addr[ADDR_W-1:0]),
        .last_idx_i (last_index(req_size)),
        .idx_o      (idx),
        .addr_o     (mem_address),
        .last_o     (last)
    );

    // Next-state logic: IDLE -> XFER/RESP, XFER -> RESP on last byte, RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = reject ? ST_RESP : ST_XFER;
            ST_XFER: if (last)      state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Merge the byte being read this cycle into the load buffer and pick the store byte.
    always_comb begin
        ld_next = ld_buf_q;
        wr_byte = wdata_q[7:0];
        case (idx)
            2'd0: begin ld_next[7:0]   = mem_read_data; wr_byte = wdata_q[7:0];   end
            2'd1: begin ld_next[15:8]  = mem_read_data; wr_byte = wdata_q[15:8];  end
            2'd2: begin ld_next[23:16] = mem_read_data; wr_byte = wdata_q[23:16]; end
            default: begin ld_next[31:24] = mem_read_data; wr_byte = wdata_q[31:24]; end
        endcase
    end

    // State, request capture, load assembly and response data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            ld_buf_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= req_we;
                wdata_q  <= req_wdata;
                err_q    <= reject;
                ld_buf_q <= '0;
            end
            if (in_xfer && !we_q) begin
                ld_buf_q <= ld_next;
                if (last) rdata_q <= ld_next;
            end
        end
    end

    assign req_ready        = (state_q == ST_IDLE);
    assign rsp_valid        = (state_q == ST_RESP);
    assign rsp_err          = err_q;
    assign rsp_rdata        = rdata_q;
    assign mem_write_data   = wr_byte;
    assign mem_write_enable = in_xfer && we_q;
    assign dbg_state        = state_q;

endmodule
